e203_tb_cmt_mon: RTL and testbench

- Parametrised commit monitor and interrupt stimulus generator for the e203 simulation top.
- Observes the commit stage (valid + PC) and the EXU dispatch handshake.
- Keeps cycle, retire and end-marker counters and produces sticky done/timeout flags.
- Drives IRQ_CH independent pseudo-random interrupt lines. Each line is held until its handler PC commits.

---
 rtl/e203_tb_cmt_mon_if.sv | 15 +
 rtl/e203_tb_cmt_mon.sv | 156 +++++++++++++++
 tb/tb_e203_tb_cmt_mon.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/e203_tb_cmt_mon_if.sv
// Commit-stage and EXU dispatch observation bundle for the commit monitor.
// Latency: n/a (wires only).
// Backpressure: none; the monitor only observes, it never stalls the core.
interface e203_tb_cmt_mon_if #(
  parameter int PC_W = 32
);
  logic            cmt_valid;
  logic [PC_W-1:0] cmt_pc;
  logic            exu_i_valid;
  logic            exu_i_ready;

  // The core side drives, the monitor side observes.
  modport master (output cmt_valid, cmt_pc, exu_i_valid, exu_i_ready);
  modport slave  (input  cmt_valid, cmt_pc, exu_i_valid, exu_i_ready);
endinterface

// File: rtl/e203_tb_cmt_mon.sv
// Commit monitor: cycle/retire/end-marker counters, done/timeout flags, random IRQ injection.
// Latency: counters and flags update on the edge after the observed event; irq_o is one edge behind the channel state.
// Backpressure: none; purely observational, inputs are never stalled.
module e203_tb_cmt_mon #(
  parameter int          PC_W   = 32,
  parameter int          CNT_W  = 32,
  parameter int          IRQ_CH = 3,
  parameter int          WAIT_W = 10,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  e203_tb_cmt_mon_if.slave       cmt,
  input  logic [PC_W-1:0]        cfg_end_pc,
  input  logic [PC_W-1:0]        cfg_arm_pc,
  input  logic [IRQ_CH*PC_W-1:0] cfg_ack_pc,
  input  logic [CNT_W-1:0]       cfg_end_hits,
  input  logic [CNT_W-1:0]       cfg_stop_hits,
  input  logic [CNT_W-1:0]       cfg_timeout,
  input  logic [WAIT_W-1:0]      cfg_wait_mask,
  input  logic [IRQ_CH-1:0]      irq_en,
  output logic [IRQ_CH-1:0]      irq_o,
  output logic                   irq_quiet,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic [CNT_W-1:0]       end_hit_cnt,
  output logic [CNT_W-1:0]       end_cycle,
  output logic                   done,
  output logic                   timeout
);

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [WAIT_W:0]   WAIT_ONE = (WAIT_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ASSERT} st_t;

  logic              end_hit;
  logic              arm_hit;
  logic              dispatch;
  logic              inject_stop;
  logic              armed;
  logic              end_seen;
  logic [15:0]       lfsr;
  logic [IRQ_CH-1:0] idle_vec;
  logic [IRQ_CH-1:0] asrt_vec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign end_hit     = cmt.cmt_valid && (cmt.cmt_pc == cfg_end_pc);
  assign arm_hit     = cmt.cmt_valid && (cmt.cmt_pc == cfg_arm_pc);
  assign dispatch    = cmt.exu_i_valid && cmt.exu_i_ready;
  assign inject_stop = end_hit_cnt > cfg_stop_hits;
  assign irq_quiet   = &idle_vec;

  // Saturating counters; retire counting freezes once the end marker has been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retire_cnt  <= '0;
      end_hit_cnt <= '0;
      end_cycle   <= '0;
      end_seen    <= 1'b0;
    end else begin
      cycle_cnt <= sat_inc(cycle_cnt);
      if (dispatch && !end_seen) retire_cnt <= sat_inc(retire_cnt);
      if (end_hit) begin
        end_hit_cnt <= sat_inc(end_hit_cnt);
        end_seen    <= 1'b1;
        if (!end_seen) end_cycle <= cycle_cnt;
      end
    end
  end

  // Sticky flags and arming; all clear only on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      timeout <= 1'b0;
      armed   <= 1'b0;
    end else begin
      done    <= done | (end_hit_cnt >= cfg_end_hits);
      timeout <= timeout | ((cfg_timeout != '0) && (cycle_cnt == cfg_timeout));
      armed   <= armed | arm_hit;
    end
  end

  // Galois LFSR x^16+x^14+x^13+x^11+1, free-running every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Interrupt lines lag the channel state by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_o <= '0;
    else     irq_o <= asrt_vec;
  end

  for (genvar c = 0; c < IRQ_CH; c++) begin : g_ch
    st_t             state;
    st_t             state_nxt;
    logic [WAIT_W:0] cnt;
    logic [WAIT_W:0] cnt_nxt;
    logic [WAIT_W-1:0] rnd;
    logic [WAIT_W:0] delay;
    logic            ack;

    // Each channel sees the LFSR rotated left by 5*c so draws differ between channels.
    for (genvar i = 0; i < WAIT_W; i++) begin : g_rot
      assign rnd[i] = lfsr[(i + 16 - ((5 * c) % 16)) % 16];
    end

    assign delay       = {1'b0, rnd & cfg_wait_mask} + WAIT_ONE;
    assign ack         = cmt.cmt_valid && (cmt.cmt_pc == cfg_ack_pc[c*PC_W +: PC_W]);
    assign idle_vec[c] = (state == S_IDLE);
    assign asrt_vec[c] = (state == S_ASSERT);

    // Channel sequencing: random wait, then hold the line until the handler exit commits.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
        S_IDLE: begin
          if (armed && irq_en[c] && !inject_stop) begin
            state_nxt = S_WAIT;
            cnt_nxt   = delay;
          end
        end
        S_WAIT: begin
          if (!irq_en[c] || inject_stop) state_nxt = S_IDLE;
          else if (cnt == WAIT_ONE)      state_nxt = S_ASSERT;
          else                           cnt_nxt   = cnt - WAIT_ONE;
        end
        S_ASSERT: begin
          if (!irq_en[c] || ack) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    // Channel state register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_e203_tb_cmt_mon.sv
// Randomized bench for the commit monitor with a timestamp-based reference model and scoreboard.
// Latency: expected state is queued per clock edge and popped just after that edge.
// Backpressure: none; every edge produces one observation.
module tb_e203_tb_cmt_mon;
  localparam int PC_W = 32, CNT_W = 32, IRQ_CH = 3, WAIT_W = 10;
  localparam longint MAXC = 64'hFFFF_FFFF;
  localparam logic [PC_W-1:0] END_PC = 32'h8000_0086;
  localparam logic [PC_W-1:0] ARM_PC = 32'h8000_0010;

  logic clk = 1'b0, rst = 1'b0, clk_run = 1'b0;
  e203_tb_cmt_mon_if #(.PC_W(PC_W)) cmt_if ();

  logic [PC_W-1:0]        cfg_end_pc, cfg_arm_pc;
  logic [IRQ_CH*PC_W-1:0] cfg_ack_pc;
  logic [CNT_W-1:0]       cfg_end_hits, cfg_stop_hits, cfg_timeout;
  logic [WAIT_W-1:0]      cfg_wait_mask;
  logic [IRQ_CH-1:0]      irq_en;
  logic [IRQ_CH-1:0]      irq_o;
  logic                   irq_quiet, done, timeout;
  logic [CNT_W-1:0]       cycle_cnt, retire_cnt, end_hit_cnt, end_cycle;

  e203_tb_cmt_mon #(.PC_W(PC_W), .CNT_W(CNT_W), .IRQ_CH(IRQ_CH), .WAIT_W(WAIT_W), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .cmt(cmt_if),
    .cfg_end_pc(cfg_end_pc), .cfg_arm_pc(cfg_arm_pc), .cfg_ack_pc(cfg_ack_pc),
    .cfg_end_hits(cfg_end_hits), .cfg_stop_hits(cfg_stop_hits), .cfg_timeout(cfg_timeout),
    .cfg_wait_mask(cfg_wait_mask), .irq_en(irq_en), .irq_o(irq_o), .irq_quiet(irq_quiet),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .end_hit_cnt(end_hit_cnt),
    .end_cycle(end_cycle), .done(done), .timeout(timeout)
  );

  // Gated clock so reset can be exercised with no edges at all.
  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
    else         clk = 1'b0;
  end

  typedef struct {
    logic [2:0] irq;
    logic       quiet;
    longint     cyc, ret, ehc, ecyc;
    logic       done, tmo;
  } exp_t;

  exp_t   q[$];
  int     n_tests = 0, n_fail = 0;
  event   mon_ev;
  bit     tracking = 1'b0;

  // Reference model: channel activity is a timestamp (edge index at which the line is high internally).
  longint m_cyc, m_ret, m_ehc, m_ecyc;
  bit     m_seen, m_done, m_tmo, m_armed;
  int     m_lfsr;
  longint fire_at [IRQ_CH];
  logic [2:0] m_irq;

  function automatic longint sat(input longint v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  function automatic int rotl16(input int x, input int s);
    int sh;
    sh = s % 16;
    return ((x << sh) | (x >> (16 - sh))) & 16'hFFFF;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_ret = 0; m_ehc = 0; m_ecyc = 0;
    m_seen = 0; m_done = 0; m_tmo = 0; m_armed = 0;
    m_lfsr = 16'hACE1;
    m_irq = '0;
    for (int c = 0; c < IRQ_CH; c++) fire_at[c] = -1;
  endtask

  task automatic model_step();
    bit cv, end_hit, stop, ack, act;
    logic [PC_W-1:0] pc;
    int d;
    cv      = cmt_if.cmt_valid;
    pc      = cmt_if.cmt_pc;
    end_hit = cv && (pc == cfg_end_pc);
    stop    = m_ehc > longint'(cfg_stop_hits);
    for (int c = 0; c < IRQ_CH; c++) begin
      ack = cv && (pc == cfg_ack_pc[c*PC_W +: PC_W]);
      act = (fire_at[c] >= 0) && (m_cyc >= fire_at[c]);
      m_irq[c] = act;
      if (fire_at[c] < 0) begin
        if (m_armed && irq_en[c] && !stop) begin
          d = (rotl16(m_lfsr, 5 * c) & ((1 << WAIT_W) - 1) & int'(cfg_wait_mask)) + 1;
          fire_at[c] = m_cyc + d + 1;
        end
      end else if (act) begin
        if (!irq_en[c] || ack) fire_at[c] = -1;
      end else if (!irq_en[c] || stop) begin
        fire_at[c] = -1;
      end
    end
    if (m_ehc >= longint'(cfg_end_hits)) m_done = 1;
    if (cfg_timeout != 0 && m_cyc == longint'(cfg_timeout)) m_tmo = 1;
    if (cmt_if.exu_i_valid && cmt_if.exu_i_ready && !m_seen) m_ret = sat(m_ret);
    if (end_hit) begin
      if (!m_seen) m_ecyc = m_cyc;
      m_seen = 1;
      m_ehc  = sat(m_ehc);
    end
    if (cv && pc == cfg_arm_pc) m_armed = 1;
    m_cyc  = sat(m_cyc);
    m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 16'hB400 : 0);
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    e.irq   = m_irq;
    e.quiet = 1'b1;
    for (int c = 0; c < IRQ_CH; c++) if (fire_at[c] >= 0) e.quiet = 1'b0;
    e.cyc = m_cyc; e.ret = m_ret; e.ehc = m_ehc; e.ecyc = m_ecyc;
    e.done = m_done; e.tmo = m_tmo;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (tracking) begin
    #1;
    ->mon_ev;
  end

  // Monitor: pops one expected snapshot per observation and compares every output.
  initial forever begin
    exp_t e;
    @(mon_ev);
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_underflow: DUT observed with no expected entry at t=%0t", $time);
    end else begin
      e = q.pop_front();
      chk("irq_o",       64'(irq_o),       64'(e.irq));
      chk("irq_quiet",   64'(irq_quiet),   64'(e.quiet));
      chk("cycle_cnt",   64'(cycle_cnt),   64'(e.cyc));
      chk("retire_cnt",  64'(retire_cnt),  64'(e.ret));
      chk("end_hit_cnt", 64'(end_hit_cnt), 64'(e.ehc));
      chk("end_cycle",   64'(end_cycle),   64'(e.ecyc));
      chk("done",        64'(done),        64'(e.done));
      chk("timeout",     64'(timeout),     64'(e.tmo));
    end
  end

  task automatic idle_inputs();
    cmt_if.cmt_valid   = 1'b0;
    cmt_if.cmt_pc      = '0;
    cmt_if.exu_i_valid = 1'b0;
    cmt_if.exu_i_ready = 1'b0;
  endtask

  // One clock: inputs are already applied; predict the post-edge state, then wait out the edge.
  task automatic cycle();
    model_step();
    q.push_back(make_exp());
    @(negedge clk);
  endtask

  // Reset with the clock stopped, check the immediate effect, then release at a negedge.
  task automatic do_reset();
    tracking = 1'b0;
    clk_run  = 1'b0;
    #3;
    idle_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    q.push_back(make_exp());
    ->mon_ev;
    #1;
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    tracking = 1'b1;
  endtask

  // end_pm / ack_pm are per-mille chances per cycle of committing the end PC / a handler-exit PC.
  task automatic run_seg(input int ncyc, input int end_pm, input int ack_pm, input bit rand_en, input bit directed);
    for (int i = 0; i < ncyc; i++) begin
      int r;
      if (directed) begin
        cmt_if.cmt_valid   = (m_cyc >= 50 && m_cyc <= 120 && (m_cyc % 10) == 0);
        cmt_if.cmt_pc      = END_PC;
        cmt_if.exu_i_valid = 1'b1;
        cmt_if.exu_i_ready = 1'b1;
      end else begin
        r = int'($urandom_range(0, 999));
        cmt_if.cmt_valid = 1'($urandom_range(0, 1));
        if (r < end_pm)                 cmt_if.cmt_pc = END_PC;
        else if (r < end_pm + 40)       cmt_if.cmt_pc = ARM_PC;
        else if (r < end_pm + 40 + ack_pm)
          cmt_if.cmt_pc = cfg_ack_pc[$urandom_range(0, IRQ_CH - 1)*PC_W +: PC_W];
        else                            cmt_if.cmt_pc = 32'h9000_0000 | PC_W'($urandom_range(0, 4095));
        cmt_if.exu_i_valid = 1'($urandom_range(0, 1));
        cmt_if.exu_i_ready = 1'($urandom_range(0, 1));
        if (rand_en && $urandom_range(0, 63) == 0) irq_en = IRQ_CH'($urandom_range(0, 7));
      end
      cycle();
    end
  endtask

  initial begin
    cfg_end_pc    = END_PC;
    cfg_arm_pc    = ARM_PC;
    cfg_ack_pc    = {32'h8000_00c0, 32'h8000_00b0, 32'h8000_00a6};
    cfg_end_hits  = 8;
    cfg_stop_hits = 32'hFFFF_FFFF;
    cfg_timeout   = 0;
    cfg_wait_mask = 10'h007;
    irq_en        = '0;
    idle_inputs();

    // Reset state, then 100 quiet cycles.
    do_reset();
    for (int i = 0; i < 100; i++) cycle();

    // Directed end-marker hits at cycles 50..120 with a dispatch every cycle.
    do_reset();
    run_seg(200, 0, 0, 1'b0, 1'b1);

    // Minimum delay, random enables, acks and occasional end hits.
    cfg_wait_mask = '0; cfg_stop_hits = 20; irq_en = 3'b111;
    do_reset();
    run_seg(1500, 5, 60, 1'b1, 1'b0);

    // Reset mid-assert with the clock stopped; the LFSR sequence must restart identically.
    cfg_wait_mask = 10'h03F; irq_en = 3'b111; cfg_stop_hits = 32'hFFFF_FFFF;
    do_reset();
    for (int k = 0; k < 2000 && m_irq == 3'b000; k++) run_seg(1, 0, 0, 1'b0, 1'b0);
    run_seg(3, 0, 0, 1'b0, 1'b0);
    do_reset();
    run_seg(400, 0, 60, 1'b0, 1'b0);

    // Timeout at 1000 with no end-marker commits; end_hits = 0 makes done rise at once.
    cfg_timeout = 1000; cfg_end_hits = 0; cfg_wait_mask = 10'h01F;
    do_reset();
    run_seg(1200, 0, 60, 1'b1, 1'b0);

    // Injection stop after the third end hit, full delay range, timeout disabled for 5000 cycles.
    cfg_timeout = 0; cfg_end_hits = 8; cfg_stop_hits = 2; cfg_wait_mask = 10'h3FF; irq_en = 3'b111;
    do_reset();
    run_seg(5000, 2, 60, 1'b0, 1'b0);

    tracking = 1'b0;
    #20;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
